// File: rtl/sm_testx_shift_reg.sv
// Pattern/capture engine for the config shift-register tests: serves a rotating
// 768-bit pattern to the test1 sequencer and captures/compares the chip's serial output.
module sm_testx_shift_reg #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned NWORDS = 24,
    parameter int unsigned CNT_W  = 14
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              enable,
    input  logic              wr_en,
    input  logic [4:0]        wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [4:0]        rd_addr,
    output logic [DATA_W-1:0] rd_pattern,
    output logic [DATA_W-1:0] rd_capture,
    input  logic              shift_reg_load,
    input  logic              shift_reg_shift,
    input  logic              config_out_bit,
    output logic              shift_reg_bit0,
    output logic [CNT_W-1:0]  shift_reg_shift_cnt,
    output logic [CNT_W-1:0]  shift_reg_shift_cnt_max,
    output logic              capture_done,
    output logic [9:0]        mismatch_cnt
);

    localparam int unsigned     SHIFT_BITS = NWORDS * DATA_W;
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(2 * SHIFT_BITS - 1);
    localparam logic [CNT_W-1:0] PASS2_START = CNT_W'(SHIFT_BITS);
    localparam logic [9:0]       MM_MAX    = 10'(SHIFT_BITS);

    logic [SHIFT_BITS-1:0] pat_q;
    logic [SHIFT_BITS-1:0] work_q;
    logic [SHIFT_BITS-1:0] cap_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [9:0]            mm_q;
    logic                  final_q;
    logic [DATA_W-1:0]     pat_word;
    logic [DATA_W-1:0]     cap_word;
    logic                  do_load;
    logic                  do_shift;
    logic                  second_pass;

    always_comb begin
        pat_word = '0;
        cap_word = '0;
        for (int unsigned i = 0; i < NWORDS; i++) begin
            if (rd_addr == 5'(i)) begin
                pat_word = pat_q[i*DATA_W +: DATA_W];
                cap_word = cap_q[i*DATA_W +: DATA_W];
            end
        end
    end

    // The counter saturates at CNT_MAX, so the 1536th shift (the last second-pass
    // bit) is tracked by final_q; only shifts after that one are dropped.
    always_comb begin
        do_load     = enable && shift_reg_load;
        do_shift    = enable && shift_reg_shift && !shift_reg_load && !final_q;
        second_pass = (cnt_q >= PASS2_START);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pat_q <= '0;
        end else if (wr_en) begin
            for (int unsigned i = 0; i < NWORDS; i++) begin
                if (wr_addr == 5'(i)) begin
                    pat_q[i*DATA_W +: DATA_W] <= wr_data;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_pattern <= '0;
            rd_capture <= '0;
        end else if (enable) begin
            rd_pattern <= pat_word;
            rd_capture <= cap_word;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            work_q  <= '0;
            cap_q   <= '0;
            cnt_q   <= '0;
            mm_q    <= '0;
            final_q <= 1'b0;
        end else if (do_load) begin
            work_q  <= pat_q;
            cap_q   <= '0;
            cnt_q   <= '0;
            mm_q    <= '0;
            final_q <= 1'b0;
        end else if (do_shift) begin
            work_q <= {work_q[0], work_q[SHIFT_BITS-1:1]};
            if (cnt_q == CNT_MAX) begin
                final_q <= 1'b1;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (second_pass) begin
                cap_q <= {config_out_bit, cap_q[SHIFT_BITS-1:1]};
                if ((config_out_bit != work_q[0]) && (mm_q != MM_MAX)) begin
                    mm_q <= mm_q + 1'b1;
                end
            end
        end
    end

    assign shift_reg_bit0          = work_q[0];
    assign shift_reg_shift_cnt     = cnt_q;
    assign shift_reg_shift_cnt_max = CNT_MAX;
    assign capture_done            = (cnt_q == CNT_MAX);
    assign mismatch_cnt            = mm_q;

endmodule

// File: tb/tb_sm_testx_shift_reg.sv
// Randomized bench for sm_testx_shift_reg against a bit-index reference model
// of the pattern rotation, external config chain and capture.
module tb_sm_testx_shift_reg;

    localparam int SB = 768;

    logic        clk = 1'b0;
    logic        resetn;
    logic        enable;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [4:0]  rd_addr;
    logic [31:0] rd_pattern;
    logic [31:0] rd_capture;
    logic        shift_reg_load;
    logic        shift_reg_shift;
    logic        config_out_bit;
    logic        shift_reg_bit0;
    logic [13:0] shift_reg_shift_cnt;
    logic [13:0] shift_reg_shift_cnt_max;
    logic        capture_done;
    logic [9:0]  mismatch_cnt;

    sm_testx_shift_reg #(.DATA_W(32), .NWORDS(24), .CNT_W(14)) dut (
        .clk                     (clk),
        .resetn                  (resetn),
        .enable                  (enable),
        .wr_en                   (wr_en),
        .wr_addr                 (wr_addr),
        .wr_data                 (wr_data),
        .rd_addr                 (rd_addr),
        .rd_pattern              (rd_pattern),
        .rd_capture              (rd_capture),
        .shift_reg_load          (shift_reg_load),
        .shift_reg_shift         (shift_reg_shift),
        .config_out_bit          (config_out_bit),
        .shift_reg_bit0          (shift_reg_bit0),
        .shift_reg_shift_cnt     (shift_reg_shift_cnt),
        .shift_reg_shift_cnt_max (shift_reg_shift_cnt_max),
        .capture_done            (capture_done),
        .mismatch_cnt            (mismatch_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: buffer contents, loaded pattern, count of accepted shifts.
    logic [SB-1:0] buf_m;
    logic [SB-1:0] wpat;
    logic [SB-1:0] cap_m;
    logic [SB-1:0] chain;
    int            n_m;
    int            mm_m;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic write_word(input int a, input logic [31:0] d);
        wr_en   = 1'b1;
        wr_addr = 5'(a);
        wr_data = d;
        cyc();
        wr_en = 1'b0;
        if (a < 24) buf_m[a*32 +: 32] = d;
    endtask

    task automatic load_pat();
        shift_reg_load = 1'b1;
        cyc();
        shift_reg_load = 1'b0;
        if (enable) begin
            wpat  = buf_m;
            cap_m = '0;
            chain = '0;
            n_m   = 0;
            mm_m  = 0;
        end
    endtask

    task automatic do_shift(input bit fault);
        logic cfg;
        cfg             = chain[SB-1] ^ fault;
        config_out_bit  = cfg;
        shift_reg_shift = 1'b1;
        cyc();
        shift_reg_shift = 1'b0;
        if (enable) begin
            chain = {chain[SB-2:0], wpat[n_m % SB]};
            if (n_m < 2*SB) begin
                if (n_m >= SB) begin
                    cap_m = {cfg, cap_m[SB-1:1]};
                    if (cfg != wpat[n_m % SB]) mm_m++;
                end
                n_m++;
            end
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, "_cnt"},  64'(shift_reg_shift_cnt), 64'((n_m > 1535) ? 1535 : n_m));
        check({tag, "_bit0"}, 64'(shift_reg_bit0), 64'(wpat[n_m % SB]));
        check({tag, "_done"}, 64'(capture_done), 64'(n_m >= 1535));
        check({tag, "_mm"},   64'(mismatch_cnt), 64'(mm_m));
    endtask

    task automatic read_check(input int a);
        logic [31:0] ep, ec;
        ep = '0;
        ec = '0;
        if (a < 24) begin
            ep = buf_m[a*32 +: 32];
            ec = cap_m[a*32 +: 32];
        end
        rd_addr = 5'(a);
        cyc();
        check("rd_pattern", 64'(rd_pattern), 64'(ep));
        check("rd_capture", 64'(rd_capture), 64'(ec));
    endtask

    task automatic random_pattern();
        for (int a = 0; a < 24; a++) write_word(a, $urandom);
    endtask

    task automatic run_pass(input int pulses, input bit inject, input bit jitter);
        for (int k = 0; k < pulses; k++) begin
            if (jitter && ($urandom_range(0, 5) == 0)) cyc();
            if (jitter && ($urandom_range(0, 15) == 0)) begin
                enable = 1'b0;
                do_shift(1'b0);
                enable = 1'b1;
            end
            do_shift(inject && ((n_m == SB + 5) || (n_m == SB + 700)));
            if (jitter || (k % 64 == 0)) check_state("pass");
        end
    endtask

    initial begin
        resetn = 1'b0; enable = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        rd_addr = '0; shift_reg_load = 1'b0; shift_reg_shift = 1'b0; config_out_bit = 1'b0;
        buf_m = '0; wpat = '0; cap_m = '0; chain = '0; n_m = 0; mm_m = 0;
        #1;
        check("rst_cnt", 64'(shift_reg_shift_cnt), 64'd0);
        check("rst_bit0", 64'(shift_reg_bit0), 64'd0);
        check("rst_cnt_max", 64'(shift_reg_shift_cnt_max), 64'd1535);
        cyc();
        resetn = 1'b1;
        cyc();

        // Write/read basics and the out-of-range write port.
        write_word(0, 32'hA5A5_0001);
        write_word(23, 32'h8000_0000);
        write_word(24, 32'hFFFF_FFFF);
        load_pat();
        check("load_bit0", 64'(shift_reg_bit0), 64'd1);
        check_state("load");
        read_check(23);
        check("rd23_const", 64'(rd_pattern), 64'h8000_0000);
        read_check(24);
        for (int a = 0; a < 24; a++) read_check(a);

        // Mid-stream asynchronous reset.
        random_pattern();
        load_pat();
        run_pass(400, 1'b0, 1'b0);
        check_state("pre_rst");
        #2 resetn = 1'b0;
        #1;
        check("arst_cnt", 64'(shift_reg_shift_cnt), 64'd0);
        check("arst_bit0", 64'(shift_reg_bit0), 64'd0);
        check("arst_done", 64'(capture_done), 64'd0);
        check("arst_mm", 64'(mismatch_cnt), 64'd0);
        check("arst_rdp", 64'(rd_pattern), 64'd0);
        check("arst_rdc", 64'(rd_capture), 64'd0);
        check("arst_max", 64'(shift_reg_shift_cnt_max), 64'd1535);
        buf_m = '0; wpat = '0; cap_m = '0; chain = '0; n_m = 0; mm_m = 0;
        cyc();
        resetn = 1'b1;
        for (int a = 0; a < 24; a++) read_check(a);

        // Loopback pass with randomized gaps and gated pulses.
        random_pattern();
        load_pat();
        run_pass(1536, 1'b0, 1'b1);
        check("lb_cnt", 64'(shift_reg_shift_cnt), 64'd1535);
        check("lb_done", 64'(capture_done), 64'd1);
        check("lb_mm", 64'(mismatch_cnt), 64'd0);
        for (int a = 0; a < 24; a++) begin
            read_check(a);
            check("lb_cap_eq_pat", 64'(rd_capture), 64'(wpat[a*32 +: 32]));
        end

        // Fault injection on second-pass shifts 5 and 700.
        load_pat();
        run_pass(1536, 1'b1, 1'b0);
        check("fi_mm", 64'(mismatch_cnt), 64'd2);
        for (int a = 0; a < 24; a++) read_check(a);
        rd_addr = 5'd0;  cyc();
        check("fi_w0", 64'(rd_capture ^ rd_pattern), 64'h20);
        rd_addr = 5'd21; cyc();
        check("fi_w21", 64'(rd_capture ^ rd_pattern), 64'h1000_0000);

        // Saturation after 1540 pulses.
        load_pat();
        run_pass(1540, 1'b0, 1'b0);
        check_state("sat");
        check("sat_cnt", 64'(shift_reg_shift_cnt), 64'd1535);
        for (int a = 0; a < 24; a++) begin
            read_check(a);
            check("sat_cap_eq_pat", 64'(rd_capture), 64'(wpat[a*32 +: 32]));
        end

        // Load and shift on the same cycle.
        run_pass(0, 1'b0, 1'b0);
        load_pat();
        run_pass(37, 1'b0, 1'b0);
        shift_reg_shift = 1'b1;
        load_pat();
        shift_reg_shift = 1'b0;
        check("ls_cnt", 64'(shift_reg_shift_cnt), 64'd0);
        check("ls_bit0", 64'(shift_reg_bit0), 64'(wpat[0]));

        // Enable gating.
        run_pass(3, 1'b0, 1'b0);
        enable = 1'b0;
        for (int k = 0; k < 10; k++) do_shift(1'b0);
        load_pat();
        check("en_cnt", 64'(shift_reg_shift_cnt), 64'd3);
        check("en_bit0", 64'(shift_reg_bit0), 64'(wpat[3]));
        write_word(5, $urandom);
        enable = 1'b1;
        read_check(5);
        check_state("en_after");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
